// File: rtl/add_seq_pkg.sv
// add_seq_pkg: shared FSM encoding, nibble width and index-width helper for add_seq_ctrl
package add_seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam int NIBBLE_W = 4;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/add_seq_ctrl_if.sv
// add_seq_ctrl_if: operand/result handshake bundle for add_seq_ctrl
//   master: operand source + result consumer (drives in_valid, a, b, c_in, [sub], out_ready)
//   slave : the sequencer (drives in_ready, out_valid, sum, c_out, busy)
//   sub exists only when ADD_SEQ_SUB_EN is defined
interface add_seq_ctrl_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
`ifdef ADD_SEQ_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             busy;
    modport master (
        output in_valid, a, b, c_in,
`ifdef ADD_SEQ_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, c_out, busy
    );
    modport slave (
        input  in_valid, a, b, c_in,
`ifdef ADD_SEQ_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, c_out, busy
    );
endinterface

// File: rtl/add_4bit.sv
// add_4bit: 4-bit carry-lookahead adder slice
//   a, b : 4-bit operands    ci : carry in
//   s    : 4-bit sum         co : carry out
module add_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:1] c;
    assign g = a & b;
    assign p = a ^ b;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);
    assign s = p ^ {c[3:1], ci};
endmodule

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: WIDTH-bit adder time-sharing one add_4bit slice, one nibble per cycle, LSB nibble first
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : add_seq_ctrl_if.slave (operand handshake in, result handshake out, busy)
//   ADD_SEQ_SUB_EN : when defined, bus.sub selects a-b (b inverted, initial carry forced to 1)
module add_seq_ctrl #(parameter int WIDTH = 16) (
    input  logic          clk,
    input  logic          rst_n,
    add_seq_ctrl_if.slave bus
);
    import add_seq_pkg::*;

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = idx_w(NIBBLES);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               c_out_q, c_out_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NIBBLE_W-1:0] nib_s;
    logic               nib_c;
    logic [WIDTH-1:0]   b_in;
    logic               c_init;

`ifdef ADD_SEQ_SUB_EN
    assign b_in   = bus.sub ? ~bus.b : bus.b;
    assign c_init = bus.sub | bus.c_in;
`else
    assign b_in   = bus.b;
    assign c_init = bus.c_in;
`endif

    add_4bit u_slice (
        .a  (a_q[NIBBLE_W-1:0]),
        .b  (b_q[NIBBLE_W-1:0]),
        .ci (carry_q),
        .s  (nib_s),
        .co (nib_c)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        c_out_d  = c_out_q;
        idx_d    = idx_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                a_d     = bus.a;
                b_d     = b_in;
                carry_d = c_init;
                idx_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                // new nibble enters at the top so nibble 0 lands at [3:0] after NIBBLES shifts
                sum_sh_d = (sum_sh_q >> NIBBLE_W) | (WIDTH'(nib_s) << (WIDTH - NIBBLE_W));
                a_d      = a_q >> NIBBLE_W;
                b_d      = b_q >> NIBBLE_W;
                carry_d  = nib_c;
                idx_d    = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    state_d = DONE;
                    sum_d   = sum_sh_d;
                    c_out_d = nib_c;
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            c_out_q  <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            c_out_q  <= c_out_d;
            idx_q    <= idx_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == RUN);
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
endmodule
